// File: rtl/counter_sched_pkg.sv
// Shared types and default parameter values for the shared-counter scheduler.
package counter_sched_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } sched_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int WIDTH_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/counter_rr_scheduler_rr_arbiter.sv
// Combinational round-robin search: the first masked request at or after
// the pointer (ascending, wrapping) wins.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & mask;

    // Walk the candidates starting at the pointer; keep the first hit.
    always_comb begin
        int pos;
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(pointer) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!valid && cand[pos]) begin
                valid  = 1'b1;
                index  = pos[IDX_W-1:0];
                onehot = NUM_REQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler granting increments of one shared wrap-around
// counter, with an optional locked burst for the current owner.
module counter_rr_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   count,
    output logic               wrap,
    output logic               busy
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               wrap_q, wrap_d;

    logic [NUM_REQ-1:0] arb_mask;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_valid;
    logic               burst_full;
    logic               regrant;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign burst_full = (burst_q == BURST_W'(MAX_BURST));
    assign regrant    = (state_q == OWNED) && req[owner_q] && lock[owner_q] && !burst_full;

    // An owner that has used its whole burst must yield to the others.
    always_comb begin
        arb_mask = '1;
        if (state_q == OWNED && burst_full) begin
            arb_mask[owner_q] = 1'b0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .mask    (arb_mask),
        .pointer (ptr_q),
        .onehot  (arb_onehot),
        .index   (arb_index),
        .valid   (arb_valid)
    );

    // Next-state: clear beats everything, then owner re-grant, then arbitration.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        count_d = count_q;
        gnt_d   = '0;
        wrap_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            burst_d = '0;
            count_d = '0;
        end else if (regrant) begin
            gnt_d   = NUM_REQ'(1) << owner_q;
            count_d = count_q + 1'b1;
            wrap_d  = (count_q == '1);
            burst_d = burst_q + 1'b1;
            ptr_d   = next_ptr(owner_q);
        end else if (arb_valid) begin
            gnt_d   = arb_onehot;
            count_d = count_q + 1'b1;
            wrap_d  = (count_q == '1);
            ptr_d   = next_ptr(arb_index);
            owner_d = arb_index;
            if (lock[arb_index]) begin
                state_d = OWNED;
                burst_d = BURST_W'(1);
            end else begin
                state_d = IDLE;
                burst_d = '0;
            end
        end else begin
            state_d = IDLE;
            burst_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gnt   = gnt_q;
    assign count = count_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q == OWNED);

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: a vector table plus hand-written
// multi-cycle sequences, checked through an expected-result queue.
module tb_counter_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset, clr;
    logic [3:0] req, lock, gnt, count;
    logic       wrap, busy;

    counter_rr_scheduler #(.NUM_REQ(4), .WIDTH(4), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .req   (req),
        .lock  (lock),
        .gnt   (gnt),
        .count (count),
        .wrap  (wrap),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic [3:0] count;
        logic       wrap;
        logic       busy;
    } vec_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] count;
        logic       wrap;
        logic       busy;
    } exp_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic r, input logic c, input logic [3:0] rq,
                                input logic [3:0] lk, input logic [3:0] g,
                                input logic [3:0] cnt, input logic w, input logic b);
        vec_t v;
        v.rst = r; v.clr = c; v.req = rq; v.lock = lk;
        v.gnt = g; v.count = cnt; v.wrap = w; v.busy = b;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic step(input string name, input logic r, input logic c,
                        input logic [3:0] rq, input logic [3:0] lk,
                        input logic [3:0] g, input logic [3:0] cnt,
                        input logic w, input logic b);
        exp_t e;
        exp_t got;
        reset = r; clr = c; req = rq; lock = lk;
        e.gnt = g; e.count = cnt; e.wrap = w; e.busy = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got.gnt = gnt; got.count = count; got.wrap = wrap; got.busy = busy;
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b count=%0d wrap=%b busy=%b, expected gnt=%b count=%0d wrap=%b busy=%b",
                     name, got.gnt, got.count, got.wrap, got.busy,
                     e.gnt, e.count, e.wrap, e.busy);
        end
    endtask

    initial begin
        //               rst clr req    lock   gnt    cnt wrap busy
        vecs[0]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 0);
        vecs[1]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 0);
        vecs[2]  = mk(0, 0, 4'h1, 4'h0, 4'h1, 1,  0, 0);
        vecs[3]  = mk(0, 0, 4'h0, 4'h0, 4'h0, 1,  0, 0);
        vecs[4]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 0);
        vecs[5]  = mk(0, 0, 4'hF, 4'h0, 4'h1, 1,  0, 0);
        vecs[6]  = mk(0, 0, 4'hF, 4'h0, 4'h2, 2,  0, 0);
        vecs[7]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 3,  0, 0);
        vecs[8]  = mk(0, 0, 4'hF, 4'h0, 4'h8, 4,  0, 0);
        vecs[9]  = mk(0, 0, 4'hF, 4'h0, 4'h1, 5,  0, 0);
        vecs[10] = mk(0, 0, 4'h0, 4'h0, 4'h0, 5,  0, 0);
        vecs[11] = mk(0, 0, 4'h5, 4'h4, 4'h4, 6,  0, 1);
        vecs[12] = mk(0, 0, 4'h5, 4'h4, 4'h4, 7,  0, 1);
        vecs[13] = mk(0, 0, 4'h5, 4'h4, 4'h4, 8,  0, 1);
        vecs[14] = mk(0, 0, 4'h5, 4'h4, 4'h4, 9,  0, 1);
        vecs[15] = mk(0, 0, 4'h5, 4'h4, 4'h1, 10, 0, 0);
        vecs[16] = mk(0, 0, 4'h0, 4'h0, 4'h0, 10, 0, 0);
        vecs[17] = mk(0, 0, 4'h1, 4'h2, 4'h1, 11, 0, 0);
        vecs[18] = mk(0, 0, 4'h4, 4'h4, 4'h4, 12, 0, 1);
        vecs[19] = mk(0, 0, 4'h4, 4'h0, 4'h4, 13, 0, 0);
        vecs[20] = mk(0, 1, 4'h4, 4'h4, 4'h0, 0,  0, 0);
        vecs[21] = mk(0, 0, 4'h4, 4'h4, 4'h4, 1,  0, 1);
        vecs[22] = mk(0, 0, 4'h0, 4'h4, 4'h0, 1,  0, 0);
        vecs[23] = mk(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 0);

        reset = 1'b1; clr = 1'b0; req = '0; lock = '0;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].clr, vecs[i].req,
                 vecs[i].lock, vecs[i].gnt, vecs[i].count, vecs[i].wrap, vecs[i].busy);
        end

        // Count up to and through the wrap point.
        step("wrap_clr", 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step($sformatf("wrap_inc%0d", i), 0, 0, 4'h1, 4'h0, 4'h1,
                 4'(i % 16), (i == 16), 0);
        end
        step("wrap_idle", 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0);

        // Clear with pending requests: they survive and are granted next.
        step("clr_rst", 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("clr_up%0d", i), 0, 0, 4'h8, 4'h0, 4'h8, 4'(i), 0, 0);
        end
        step("clr_hit",   0, 1, 4'h3, 4'h0, 4'h0, 0, 0, 0);
        step("clr_pend0", 0, 0, 4'h3, 4'h0, 4'h1, 1, 0, 0);
        step("clr_pend1", 0, 0, 4'h3, 4'h0, 4'h2, 2, 0, 0);
        step("clr_idle",  0, 0, 4'h0, 4'h0, 4'h0, 2, 0, 0);

        // Reset in the middle of a locked burst.
        step("mid_rst0", 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("mid_burst%0d", i), 0, 0, 4'h4, 4'h4, 4'h4, 4'(i), 0, 1);
        end
        step("mid_rst",  1, 0, 4'h4, 4'h4, 4'h0, 0, 0, 0);
        step("mid_ptr0", 0, 0, 4'hF, 4'h0, 4'h1, 1, 0, 0);
        step("mid_idle", 0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
